// File: rtl/gpio_bank_ctrl.sv
// GPIO bank: register-mapped pad drive/enable, synchronised and debounced pad inputs,
// per-pin rise/fall edge capture into a write-1-to-clear pending register with level interrupt.
module gpio_bank_ctrl #(
    parameter int WIDTH      = 12,
    parameter int DEB_CYCLES = 4
) (
    input  logic             io_clock,
    input  logic             io_reset_n,
    input  logic [WIDTH-1:0] io_pins_read,
    output logic [WIDTH-1:0] io_pins_write,
    output logic [WIDTH-1:0] io_pins_writeEnable,
    input  logic             io_bus_sel,
    input  logic             io_bus_wr,
    input  logic [2:0]       io_bus_addr,
    input  logic [WIDTH-1:0] io_bus_wdata,
    output logic [WIDTH-1:0] io_bus_rdata,
    output logic             io_interrupt
);

    localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADDR_OUT_EN   = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [2:0] ADDR_PENDING  = 3'd5;

    logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_prev_q, stable_prev_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] out_en_q, out_en_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] w1c, rise_evt, fall_evt;
    logic             bus_wr_en, bus_rd_en;

    always_comb begin
        sync1_d       = io_pins_read;
        sync2_d       = sync1_q;
        stable_prev_d = stable;
    end

    generate
        if (DEB_CYCLES == 0) begin : g_bypass
            assign stable = sync2_q;
        end else begin : g_deb
            localparam logic [7:0] CNT_TC = 8'(DEB_CYCLES - 1);
            logic [7:0]       cnt_q [WIDTH];
            logic [7:0]       cnt_d [WIDTH];
            logic [WIDTH-1:0] stable_q, stable_d;

            // Counter only advances while the synchronised input disagrees with stable;
            // any agreeing cycle restarts the window, so short glitches never commit.
            always_comb begin
                stable_d = stable_q;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_d[i] = 8'd0;
                    if (sync2_q[i] != stable_q[i]) begin
                        if (cnt_q[i] == CNT_TC) begin
                            stable_d[i] = sync2_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end
                end
            end

            always_ff @(posedge io_clock or negedge io_reset_n) begin
                if (!io_reset_n) begin
                    stable_q <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt_q[i] <= 8'd0;
                    end
                end else begin
                    stable_q <= stable_d;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt_q[i] <= cnt_d[i];
                    end
                end
            end

            assign stable = stable_q;
        end
    endgenerate

    assign bus_wr_en = io_bus_sel & io_bus_wr;
    assign bus_rd_en = io_bus_sel & ~io_bus_wr;

    always_comb begin
        data_out_d = data_out_q;
        out_en_d   = out_en_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        rdata_d    = rdata_q;
        w1c        = '0;

        if (bus_wr_en) begin
            case (io_bus_addr)
                ADDR_DATA_OUT: data_out_d = io_bus_wdata;
                ADDR_OUT_EN:   out_en_d   = io_bus_wdata;
                ADDR_RISE_EN:  rise_en_d  = io_bus_wdata;
                ADDR_FALL_EN:  fall_en_d  = io_bus_wdata;
                ADDR_PENDING:  w1c        = io_bus_wdata;
                default:       ;
            endcase
        end

        // Edge events are applied after the clear so a coincident set wins.
        rise_evt  = stable & ~stable_prev_q & rise_en_q;
        fall_evt  = ~stable & stable_prev_q & fall_en_q;
        pending_d = (pending_q & ~w1c) | rise_evt | fall_evt;

        if (bus_rd_en) begin
            case (io_bus_addr)
                ADDR_DATA_IN:  rdata_d = stable;
                ADDR_DATA_OUT: rdata_d = data_out_q;
                ADDR_OUT_EN:   rdata_d = out_en_q;
                ADDR_RISE_EN:  rdata_d = rise_en_q;
                ADDR_FALL_EN:  rdata_d = fall_en_q;
                ADDR_PENDING:  rdata_d = pending_q;
                default:       rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_prev_q <= '0;
            data_out_q    <= '0;
            out_en_q      <= '0;
            rise_en_q     <= '0;
            fall_en_q     <= '0;
            pending_q     <= '0;
            rdata_q       <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_prev_q <= stable_prev_d;
            data_out_q    <= data_out_d;
            out_en_q      <= out_en_d;
            rise_en_q     <= rise_en_d;
            fall_en_q     <= fall_en_d;
            pending_q     <= pending_d;
            rdata_q       <= rdata_d;
        end
    end

    assign io_pins_write       = data_out_q;
    assign io_pins_writeEnable = out_en_q;
    assign io_bus_rdata        = rdata_q;
    assign io_interrupt        = |pending_q;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Directed bench for gpio_bank_ctrl at default parameters (WIDTH=12, DEB_CYCLES=4):
// register access, debounce timing, edge capture, W1C priority and reset behaviour.
module tb_gpio_bank_ctrl;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] pins_rd = '0;
    logic [W-1:0] wdata = '0;
    logic         sel = 1'b0;
    logic         wr = 1'b0;
    logic [2:0]   addr = 3'd0;
    logic [W-1:0] pins_wr;
    logic [W-1:0] pins_we;
    logic [W-1:0] rdata;
    logic         irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_bank_ctrl #(.WIDTH(W), .DEB_CYCLES(4)) dut (
        .io_clock            (clk),
        .io_reset_n          (rst_n),
        .io_pins_read        (pins_rd),
        .io_pins_write       (pins_wr),
        .io_pins_writeEnable (pins_we),
        .io_bus_sel          (sel),
        .io_bus_wr           (wr),
        .io_bus_addr         (addr),
        .io_bus_wdata        (wdata),
        .io_bus_rdata        (rdata),
        .io_interrupt        (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [W-1:0] d);
        sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a);
        sel = 1'b1; wr = 1'b0; addr = a;
        tick();
        sel = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_write", 32'(pins_wr), 32'h0);
        chk("rst_we",    32'(pins_we), 32'h0);
        chk("rst_rdata", 32'(rdata),   32'h0);
        chk("rst_irq",   32'(irq),     32'h0);
        rst_n = 1'b1;
        tick();

        // output registers drive the pads the cycle after the write edge
        bus_write(3'd2, 12'h00F);
        chk("we_next",     32'(pins_we), 32'h00F);
        chk("write_still", 32'(pins_wr), 32'h000);
        bus_write(3'd1, 12'h005);
        chk("write_next",  32'(pins_wr), 32'h005);
        bus_read(3'd1);
        chk("rd_data_out", 32'(rdata), 32'h005);
        bus_read(3'd2);
        chk("rd_out_en",   32'(rdata), 32'h00F);

        // debounce: continuous reads of DATA_IN; stable after edge k+5, seen in rdata after k+6
        sel = 1'b1; wr = 1'b0; addr = 3'd0;
        tick();
        pins_rd = 12'h008;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk($sformatf("deb_rise_e%0d", e), 32'(rdata), (e == 6) ? 32'h008 : 32'h000);
        end
        repeat (4) tick();
        pins_rd = 12'h000;
        repeat (8) tick();
        chk("deb_back0", 32'(rdata), 32'h000);

        // 3-cycle glitch must never reach DATA_IN
        pins_rd = 12'h008;
        repeat (3) tick();
        pins_rd = 12'h000;
        for (int e = 0; e < 8; e++) begin
            tick();
            chk($sformatf("glitch_e%0d", e), 32'(rdata), 32'h000);
        end
        sel = 1'b0;

        // rising edge capture on pin 0
        bus_write(3'd3, 12'h001);
        pins_rd = 12'h001;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk($sformatf("irq_rise_e%0d", e), 32'(irq), (e == 6) ? 32'h1 : 32'h0);
        end
        bus_read(3'd5);
        chk("pend_rise", 32'(rdata), 32'h001);
        bus_write(3'd3, 12'h000);
        chk("pend_kept_irq", 32'(irq), 32'h1);
        bus_write(3'd5, 12'h001);
        chk("w1c_irq", 32'(irq), 32'h0);

        // W1C coincident with a new falling edge on pin 2: set wins
        bus_write(3'd4, 12'h004);
        pins_rd = 12'h005;
        repeat (8) tick();
        chk("no_evt_rise2", 32'(irq), 32'h0);
        pins_rd = 12'h001;
        repeat (6) tick();
        bus_write(3'd5, 12'h004);
        chk("set_wins_irq", 32'(irq), 32'h1);
        bus_read(3'd5);
        chk("set_wins_pend", 32'(rdata), 32'h004);
        bus_write(3'd5, 12'h004);
        chk("w1c2_irq", 32'(irq), 32'h0);

        // reserved addresses and DATA_IN pattern read
        bus_write(3'd6, 12'hFFF);
        bus_read(3'd6);
        chk("rd_addr6", 32'(rdata), 32'h000);
        pins_rd = 12'hA5A;
        repeat (8) tick();
        bus_read(3'd7);
        chk("rd_addr7", 32'(rdata), 32'h000);
        bus_read(3'd0);
        chk("rd_a5a", 32'(rdata), 32'hA5A);
        chk("a5a_irq", 32'(irq), 32'h0);

        // reset mid-count with pads high
        pins_rd = 12'h000;
        repeat (8) tick();
        bus_write(3'd3, 12'hFFF);
        pins_rd = 12'hFFF;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we",    32'(pins_we), 32'h000);
        chk("mid_rst_write", 32'(pins_wr), 32'h000);
        chk("mid_rst_rdata", 32'(rdata),   32'h000);
        tick();
        sel = 1'b1; wr = 1'b0; addr = 3'd0;
        rst_n = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk($sformatf("rel_e%0d", e), 32'(rdata), (e == 6) ? 32'hFFF : 32'h000);
        end
        sel = 1'b0;
        repeat (3) tick();
        chk("rel_irq", 32'(irq), 32'h0);
        bus_read(3'd5);
        chk("rel_pend", 32'(rdata), 32'h000);
        bus_read(3'd3);
        chk("rel_rise_en", 32'(rdata), 32'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
